// File: rtl/sqwave_meas.sv
// Square-wave measurement: synchronizes sig_in and reports high/low phase lengths
// in clk cycles, one result per complete high+low period.
module sqwave_meas #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period_len,
  output logic             meas_valid,
  output logic             sat
);

  typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hi_hold;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   r_sat_p;
  state_t                 r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_d  <= r_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    w_s       = r_sync[SYNC_STAGES-1];
    w_rise    = w_s & ~r_s_d;
    w_fall    = ~w_s & r_s_d;
    w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;
  end

  // The edge-detect cycle is cycle 1 of the new phase, so each phase restarts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= WAIT_RISE;
      r_cnt      <= '0;
      r_hi_hold  <= '0;
      r_sat_p    <= 1'b0;
      high_len   <= '0;
      low_len    <= '0;
      period_len <= '0;
      meas_valid <= 1'b0;
      sat        <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!en) begin
        r_state   <= WAIT_RISE;
        r_cnt     <= '0;
        r_hi_hold <= '0;
        r_sat_p   <= 1'b0;
      end else begin
        case (r_state)
          WAIT_RISE: begin
            if (w_rise) begin
              r_cnt   <= CNT_ONE;
              r_state <= HIGH;
            end
          end
          HIGH: begin
            if (w_fall) begin
              r_hi_hold <= r_cnt;
              r_cnt     <= CNT_ONE;
              r_state   <= LOW;
            end else begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == CNT_MAX) r_sat_p <= 1'b1;
            end
          end
          LOW: begin
            if (w_rise) begin
              high_len   <= r_hi_hold;
              low_len    <= r_cnt;
              period_len <= {1'b0, r_hi_hold} + {1'b0, r_cnt};
              sat        <= r_sat_p;
              meas_valid <= 1'b1;
              r_sat_p    <= 1'b0;
              r_cnt      <= CNT_ONE;
              r_state    <= HIGH;
            end else begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == CNT_MAX) r_sat_p <= 1'b1;
            end
          end
          default: r_state <= WAIT_RISE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sqwave_meas.sv
// Bench for sqwave_meas: a CNT_W=8 and a CNT_W=4 instance share one stimulus and
// are checked every cycle against a run-length model of the synchronized input.
module tb_sqwave_meas;

  logic       clk = 1'b0;
  logic       rst;
  logic       sig_in;
  logic       en;
  logic [7:0] hi8, lo8;
  logic [8:0] per8;
  logic       mv8, sat8;
  logic [3:0] hi4, lo4;
  logic [4:0] per4;
  logic       mv4, sat4;

  sqwave_meas dut8 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
    .high_len(hi8), .low_len(lo8), .period_len(per8),
    .meas_valid(mv8), .sat(sat8)
  );

  sqwave_meas #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
    .high_len(hi4), .low_len(lo4), .period_len(per4),
    .meas_valid(mv4), .sat(sat4)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: sig_in/en as seen at every non-reset clock edge.
  bit hist_in [0:16383];
  bit hist_en [0:16383];
  int n    = 0;
  int seg0 = 0;
  int maxv    [2] = '{255, 15};
  int exp_hi  [2] = '{0, 0};
  int exp_lo  [2] = '{0, 0};
  int exp_sat [2] = '{0, 0};
  int exp_mv = 0;

  // Synchronized level the FSM sees at edge e: sig_in sampled two edges earlier.
  function automatic bit s_at(input int e);
    return (e - 2 >= seg0) ? hist_in[e-2] : 1'b0;
  endfunction

  function automatic bit is_rise(input int e);
    return s_at(e) && !s_at(e-1);
  endfunction

  function automatic bit is_fall(input int e);
    return !s_at(e) && s_at(e-1);
  endfunction

  initial begin
    int e, r, f, hl, ll;
    bit ok;
    forever begin
      @(posedge clk);
      exp_mv = 0;
      if (rst) begin
        seg0 = n;
      end else if (n < 16384) begin
        hist_in[n] = sig_in;
        hist_en[n] = en;
        e = n;
        n++;
        if (en && is_rise(e)) begin
          r = -1;
          for (int i = e - 1; i >= seg0; i--) begin
            if (is_rise(i)) begin
              r = i;
              break;
            end
          end
          if (r >= 0) begin
            ok = 1'b1;
            for (int i = r; i < e; i++) if (!hist_en[i]) ok = 1'b0;
            f = -1;
            for (int i = r + 1; i < e; i++) if (is_fall(i)) f = i;
            if (ok && f > r) begin
              exp_mv = 1;
              hl = f - r;
              ll = e - f;
              for (int k = 0; k < 2; k++) begin
                exp_hi[k]  = (hl < maxv[k]) ? hl : maxv[k];
                exp_lo[k]  = (ll < maxv[k]) ? ll : maxv[k];
                exp_sat[k] = (hl >= maxv[k] || ll >= maxv[k]) ? 1 : 0;
              end
            end
          end
        end
      end
      @(negedge clk);
      if (rst) begin
        exp_mv = 0;
        for (int k = 0; k < 2; k++) begin
          exp_hi[k]  = 0;
          exp_lo[k]  = 0;
          exp_sat[k] = 0;
        end
      end
      check("mv8",  int'(mv8),  exp_mv);
      check("hi8",  int'(hi8),  exp_hi[0]);
      check("lo8",  int'(lo8),  exp_lo[0]);
      check("per8", int'(per8), exp_hi[0] + exp_lo[0]);
      check("sat8", int'(sat8), exp_sat[0]);
      check("mv4",  int'(mv4),  exp_mv);
      check("hi4",  int'(hi4),  exp_hi[1]);
      check("lo4",  int'(lo4),  exp_lo[1]);
      check("per4", int'(per4), exp_hi[1] + exp_lo[1]);
      check("sat4", int'(sat4), exp_sat[1]);
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic run(input int h, input int l, input int np);
    repeat (np) begin
      sig_in = 1'b1;
      cyc(h);
      sig_in = 1'b0;
      cyc(l);
    end
  endtask

  // Hand-computed held values for one instance (which: 0 = CNT_W 8, 1 = CNT_W 4).
  task automatic lit(input string tag, input int which, input int h, input int l,
                     input int p, input int s);
    if (which == 0) begin
      check({tag, "_hi8"},  int'(hi8),  h);
      check({tag, "_lo8"},  int'(lo8),  l);
      check({tag, "_per8"}, int'(per8), p);
      check({tag, "_sat8"}, int'(sat8), s);
    end else begin
      check({tag, "_hi4"},  int'(hi4),  h);
      check({tag, "_lo4"},  int'(lo4),  l);
      check({tag, "_per4"}, int'(per4), p);
      check({tag, "_sat4"}, int'(sat4), s);
    end
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #2;
      sig_in = ~sig_in;
    end
    sig_in = 1'b0;
    en     = 1'b1;
    rst    = 1'b0;
    cyc(2);

    run(3, 4, 6);
    lit("basic", 0, 3, 4, 7, 0);
    lit("basic", 1, 3, 4, 7, 0);

    run(5, 4, 5);
    lit("change", 0, 5, 4, 9, 0);
    lit("change", 1, 5, 4, 9, 0);

    run(20, 2, 2);
    lit("satur", 0, 20, 2, 22, 0);
    lit("satur", 1, 15, 2, 17, 1);

    run(3, 4, 2);
    lit("unsat", 0, 3, 4, 7, 0);
    lit("unsat", 1, 3, 4, 7, 0);

    run(1, 1, 10);
    lit("minph", 0, 1, 1, 2, 0);
    lit("minph", 1, 1, 1, 2, 0);

    sig_in = 1'b0;
    cyc(1000);
    lit("stuck", 0, 1, 1, 2, 0);
    lit("stuck", 1, 1, 1, 2, 0);
    run(3, 4, 1);
    lit("unstuck", 0, 1, 255, 256, 1);
    lit("unstuck", 1, 1, 15, 16, 1);
    run(3, 4, 3);

    // Disable during HIGH; the whole disabled window spans the next synchronized rise.
    sig_in = 1'b1;
    cyc(2);
    en = 1'b0;
    cyc(3);
    sig_in = 1'b0;
    cyc(4);
    sig_in = 1'b1;
    cyc(3);
    en = 1'b1;
    lit("hold", 0, 3, 4, 7, 0);
    lit("hold", 1, 3, 4, 7, 0);
    sig_in = 1'b0;
    cyc(4);
    run(4, 3, 3);
    lit("reen", 0, 4, 3, 7, 0);
    lit("reen", 1, 4, 3, 7, 0);

    sig_in = 1'b1;
    cyc(3);
    sig_in = 1'b0;
    cyc(3);
    rst = 1'b1;
    #1;
    lit("rstmid", 0, 0, 0, 0, 0);
    lit("rstmid", 1, 0, 0, 0, 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    run(3, 4, 3);
    lit("postrst", 0, 3, 4, 7, 0);
    lit("postrst", 1, 3, 4, 7, 0);

    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
